adc_trigger_capture: RTL

ADC_TRIGGER_CAPTURE -- requirements
Module: adc_trigger_capture

---
 rtl/adc_pkg.sv | 30 +++
 rtl/adc_capture_ram.sv | 28 ++
 rtl/adc_trigger_capture.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC trigger/capture block.
// Holds the FSM state enum, output word bundle and sample packing.
package adc_pkg;

  localparam int ADC_W  = 14;
  localparam int WORD_W = 32;
  localparam logic [15:0] HDR_TAG = 16'hADC0;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    READOUT
  } state_e;

  typedef struct packed {
    logic              v;
    logic              sop;
    logic              eop;
    logic [WORD_W-1:0] data;
  } oword_t;

  function automatic logic [WORD_W-1:0] pack_word(
    input logic [ADC_W-1:0] a,
    input logic [ADC_W-1:0] b
  );
    return {2'b00, a, 2'b00, b};
  endfunction

endpackage

// File: rtl/adc_capture_ram.sv
// Simple dual-port capture buffer, one write port, registered read.
// No reset on the array or read register so it maps to block RAM.
module adc_capture_ram
  import adc_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/adc_trigger_capture.sv
// Armed rising-edge/forced trigger, fixed-length capture, and a
// header-prefixed stream readout with a two-entry output skid.
module adc_trigger_capture
  import adc_pkg::*;
#(
  parameter int          DEPTH   = 256,
  parameter logic [15:0] HDR_TAG = adc_pkg::HDR_TAG
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic [ADC_W-1:0]  adc_a,
  input  logic [ADC_W-1:0]  adc_b,
  input  logic              arm,
  input  logic              trig_force,
  input  logic [ADC_W-1:0]  trig_level,
  input  logic [7:0]        rec_len,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);

  state_e r_state;
  state_e w_next;

  logic [7:0]       r_len;
  logic [ADC_W-1:0] r_lvl;
  logic [ADC_W-1:0] r_prev_a;
  logic             r_prev_vld;
  logic [15:0]      r_rec_cnt;
  logic [AW-1:0]    r_waddr;
  logic [AW-1:0]    r_raddr;
  logic             r_rd_done;
  logic             r_hdr_pend;
  logic             r_inflight;
  logic             r_inf_eop;
  oword_t           r_o;
  oword_t           r_s;

  logic              w_pop;
  logic              w_cross;
  logic              w_trig;
  logic              w_last_wr;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [AW-1:0]     w_len_a;
  logic [1:0]        w_occ;
  logic              w_rd;
  logic [WORD_W-1:0] w_rdata;
  oword_t            w_arr;
  oword_t            w_hdr;

  assign w_len_a   = AW'(r_len);
  assign w_pop     = r_o.v & out_ready;
  assign w_cross   = r_prev_vld
                   && (r_prev_a < r_lvl)
                   && (adc_a >= r_lvl);
  assign w_trig    = (r_state == ARMED)
                   && (w_cross || trig_force);
  assign w_last_wr = (r_state == CAPTURE)
                   && (r_waddr == w_len_a);
  assign w_we      = w_trig || (r_state == CAPTURE);
  assign w_waddr   = w_trig ? '0 : r_waddr;

  // Reads are issued only when the O/S pair can absorb the result.
  assign w_occ = 2'(r_o.v) + 2'(r_s.v)
               + 2'(r_inflight);
  assign w_rd  = (r_state == READOUT)
               && !r_rd_done
               && ((w_occ - 2'(w_pop)) < 2'd2);

  assign w_arr = '{v: 1'b1, sop: 1'b0,
                   eop: r_inf_eop, data: w_rdata};
  assign w_hdr = '{v: 1'b1, sop: 1'b1, eop: 1'b0,
                   data: {HDR_TAG, r_rec_cnt}};

  adc_capture_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (sys_clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (pack_word(adc_a, adc_b)),
    .i_re    (w_rd),
    .i_raddr (r_raddr),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (arm) w_next = ARMED;
      ARMED:
        if (w_trig)
          w_next = (r_len == 8'd0) ? READOUT : CAPTURE;
      CAPTURE:
        if (w_last_wr) w_next = READOUT;
      READOUT:
        if (w_pop && r_o.eop) w_next = IDLE;
      default:
        w_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_lvl      <= '0;
      r_prev_a   <= '0;
      r_prev_vld <= 1'b0;
      r_rec_cnt  <= '0;
      r_waddr    <= '0;
    end else begin
      r_state    <= w_next;
      r_prev_a   <= adc_a;
      r_prev_vld <= (r_state == ARMED);
      if (r_state == IDLE && arm) begin
        r_len <= rec_len;
        r_lvl <= trig_level;
      end
      if (w_trig) r_waddr <= AW'(1);
      else if (r_state == CAPTURE)
        r_waddr <= r_waddr + 1'b1;
      if (w_pop && r_o.sop)
        r_rec_cnt <= r_rec_cnt + 16'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_raddr    <= '0;
      r_rd_done  <= 1'b0;
      r_hdr_pend <= 1'b0;
      r_inflight <= 1'b0;
      r_inf_eop  <= 1'b0;
    end else begin
      r_inflight <= w_rd;
      if (w_next == READOUT && r_state != READOUT) begin
        r_hdr_pend <= 1'b1;
        r_raddr    <= '0;
        r_rd_done  <= 1'b0;
      end else begin
        if (r_state == READOUT) r_hdr_pend <= 1'b0;
        if (w_rd) begin
          r_raddr   <= r_raddr + 1'b1;
          r_inf_eop <= (r_raddr == w_len_a);
          r_rd_done <= (r_raddr == w_len_a);
        end
      end
    end
  end

  // O is the visible word; S catches a read that lands during a stall.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_o <= '0;
      r_s <= '0;
    end else if (r_state == READOUT && r_hdr_pend) begin
      r_o <= w_hdr;
    end else if (w_pop) begin
      if (r_s.v) begin
        r_o <= r_s;
        r_s <= r_inflight ? w_arr : '0;
      end else if (r_inflight) begin
        r_o <= w_arr;
      end else begin
        r_o <= '0;
      end
    end else if (!r_o.v) begin
      if (r_inflight) r_o <= w_arr;
    end else if (r_inflight) begin
      r_s <= w_arr;
    end
  end

  assign out_data  = r_o.data;
  assign out_valid = r_o.v;
  assign out_sop   = r_o.sop;
  assign out_eop   = r_o.eop;
  assign busy      = (r_state != IDLE);

endmodule
